// File: rtl/e1000_reg_pkg.sv
// e1000_reg_pkg: FSM state encodings and grant identifiers shared by the e1000 register arbiter
package e1000_reg_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_e;
  localparam logic GNT_HOST = 1'b0;
  localparam logic GNT_INT  = 1'b1;
endpackage

// File: rtl/e1000_reg_arbiter_if.sv
// e1000_reg_arbiter_if: requester, register-file and status signals of the e1000 register arbiter
interface e1000_reg_arbiter_if #(parameter int ADDR_W = 17);
  logic              h_req_i, h_we_i, h_ack_o;
  logic [ADDR_W-1:0] h_addr_i;
  logic [3:0]        h_wbe_i;
  logic [31:0]       h_wdata_i, h_rdata_o;
  logic              i_req_i, i_we_i, i_ack_o;
  logic [ADDR_W-1:0] i_addr_i;
  logic [3:0]        i_wbe_i;
  logic [31:0]       i_wdata_i, i_rdata_o;
  logic              reg_wen_o, reg_ren_o;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [3:0]        reg_wbe_o;
  logic [31:0]       reg_d_o, reg_q_i;
  logic              busy_o, gnt_o;
  modport slave (
    input  h_req_i, h_we_i, h_addr_i, h_wbe_i, h_wdata_i,
    input  i_req_i, i_we_i, i_addr_i, i_wbe_i, i_wdata_i, reg_q_i,
    output h_ack_o, h_rdata_o, i_ack_o, i_rdata_o,
    output reg_wen_o, reg_ren_o, reg_addr_o, reg_wbe_o, reg_d_o, busy_o, gnt_o
  );
  modport master (
    output h_req_i, h_we_i, h_addr_i, h_wbe_i, h_wdata_i,
    output i_req_i, i_we_i, i_addr_i, i_wbe_i, i_wdata_i, reg_q_i,
    input  h_ack_o, h_rdata_o, i_ack_o, i_rdata_o,
    input  reg_wen_o, reg_ren_o, reg_addr_o, reg_wbe_o, reg_d_o, busy_o, gnt_o
  );
endinterface

// File: rtl/e1000_rr_arb2.sv
// e1000_rr_arb2: two-way round-robin picker; on a tie grants the side that was not granted last
module e1000_rr_arb2
  import e1000_reg_pkg::*;
(
  input  logic       clk_i,
  input  logic       srst_n_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_o
);
  logic last_q, last_d;
  always_comb begin
    gnt_o = (req_i == 2'b01) ? GNT_HOST : (req_i == 2'b10) ? GNT_INT : ~last_q;
    last_d = update_i ? gnt_o : last_q;
  end
  always_ff @(posedge clk_i)
    last_q <= !srst_n_i ? GNT_INT : last_d;
endmodule

// File: rtl/e1000_reg_arbiter.sv
// e1000_reg_arbiter: shares one e1000 register-file port between host and internal requesters,
// sequencing one round-robin-granted read or write per grant with registered strobes and acks
module e1000_reg_arbiter
  import e1000_reg_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 1
) (
  input logic                clk_i,
  input logic                srst_n_i,
  e1000_reg_arbiter_if.slave bus
);
  localparam logic [2:0] CNT_LAST = 3'(RD_LAT == 0 ? 0 : RD_LAT - 1);
  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d, gnt_q, gnt_d, busy_q, busy_d;
  logic              wen_q, wen_d, ren_q, ren_d, h_ack_q, h_ack_d, i_ack_q, i_ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wbe_q, wbe_d;
  logic [31:0]       wdata_q, wdata_d, h_rdata_q, h_rdata_d, i_rdata_q, i_rdata_d;
  logic              arb_gnt, start, capture, done;

  e1000_rr_arb2 u_arb (
    .clk_i,
    .srst_n_i,
    .req_i    ({bus.i_req_i, bus.h_req_i}),
    .update_i (start),
    .gnt_o    (arb_gnt)
  );

  // capture marks the edge on which reg_q_i is valid; done marks the edge entering ACK
  always_comb begin
    start = state_q == ST_IDLE && (bus.h_req_i || bus.i_req_i);
    capture = !we_q && ((state_q == ST_ISSUE && RD_LAT == 0) || (state_q == ST_WAIT && cnt_q == CNT_LAST));
    done = capture || (state_q == ST_ISSUE && we_q);
  end

  always_comb
    state_d = start ? ST_ISSUE :
              (state_q == ST_ISSUE || state_q == ST_WAIT) ? (done ? ST_ACK : ST_WAIT) : ST_IDLE;

  always_comb begin
    we_d = start ? (arb_gnt ? bus.i_we_i : bus.h_we_i) : we_q;
    gnt_d = start ? arb_gnt : gnt_q;
    addr_d = start ? ((arb_gnt ? bus.i_addr_i : bus.h_addr_i) & ~ADDR_W'(3)) : addr_q;
    wbe_d = start ? (arb_gnt ? bus.i_wbe_i : bus.h_wbe_i) : wbe_q;
    wdata_d = start ? (arb_gnt ? bus.i_wdata_i : bus.h_wdata_i) : wdata_q;
    wen_d = start && we_d;
    ren_d = start && !we_d;
    cnt_d = state_q == ST_WAIT ? cnt_q + 3'd1 : 3'd0;
    busy_d = state_d != ST_IDLE;
    h_ack_d = done && gnt_q == GNT_HOST;
    i_ack_d = done && gnt_q == GNT_INT;
    h_rdata_d = capture && gnt_q == GNT_HOST ? bus.reg_q_i : h_rdata_q;
    i_rdata_d = capture && gnt_q == GNT_INT ? bus.reg_q_i : i_rdata_q;
  end

  always_ff @(posedge clk_i)
    if (!srst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      wbe_q     <= '0;
      wdata_q   <= '0;
      h_ack_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      h_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      wbe_q     <= wbe_d;
      wdata_q   <= wdata_d;
      h_ack_q   <= h_ack_d;
      i_ack_q   <= i_ack_d;
      h_rdata_q <= h_rdata_d;
      i_rdata_q <= i_rdata_d;
    end

  assign bus.reg_wen_o  = wen_q;
  assign bus.reg_ren_o  = ren_q;
  assign bus.reg_addr_o = addr_q;
  assign bus.reg_wbe_o  = wbe_q;
  assign bus.reg_d_o    = wdata_q;
  assign bus.h_ack_o    = h_ack_q;
  assign bus.i_ack_o    = i_ack_q;
  assign bus.h_rdata_o  = h_rdata_q;
  assign bus.i_rdata_o  = i_rdata_q;
  assign bus.busy_o     = busy_q;
  assign bus.gnt_o      = gnt_q;
endmodule

// File: tb/tb_e1000_reg_arbiter.sv
// tb_e1000_reg_arbiter: scoreboard bench; b2 runs with RD_LAT=2 via requester agents, b0 with RD_LAT=0
module tb_e1000_reg_arbiter;
  localparam int AW = 17;
  typedef struct {logic we; logic [AW-1:0] a; logic [3:0] be; logic [31:0] d;} req_t;
  typedef struct {int cyc; logic [31:0] rd;} ack_t;
  typedef struct {int cyc; logic [53:0] k;} stb_t;

  logic clk_i = 1'b0, srst_n_i = 1'b0;
  int cyc = 0, n_cmp = 0, n_err = 0;
  logic [31:0] exp_hrd = '0, exp_ird = '0;
  logic [1:0] ren_sh = '0;
  req_t hreq_q[$], ireq_q[$];
  logic [31:0] hexp[$], iexp[$];
  logic [53:0] hsexp[$], isexp[$];
  ack_t hobs[$], iobs[$];
  stb_t hsobs[$], isobs[$];
  logic gseq[$];
  int hst_q[$];
  logic [122:0] outs2, outs0;

  e1000_reg_arbiter_if #(.ADDR_W(AW)) b2 ();
  e1000_reg_arbiter_if #(.ADDR_W(AW)) b0 ();
  e1000_reg_arbiter #(.ADDR_W(AW), .RD_LAT(2)) dut2 (.clk_i(clk_i), .srst_n_i(srst_n_i), .bus(b2));
  e1000_reg_arbiter #(.ADDR_W(AW), .RD_LAT(0)) dut0 (.clk_i(clk_i), .srst_n_i(srst_n_i), .bus(b0));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] rv(input logic [AW-1:0] a);
    return a == AW'(12) ? 32'h12345678 : 32'h5A5A0000 ^ 32'(a);
  endfunction

  function automatic logic [53:0] skey(input logic we, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    return {we, a, we ? be : 4'h0, we ? d : 32'h0};
  endfunction

  // register file: data valid exactly RD_LAT cycles after the read strobe, junk otherwise
  always @(posedge clk_i) ren_sh <= {ren_sh[0], b2.reg_ren_o};
  assign b2.reg_q_i = ren_sh[1] ? rv(b2.reg_addr_o) : 32'hBADC0FFE;
  assign b0.reg_q_i = b0.reg_ren_o ? rv(b0.reg_addr_o) : 32'hBADC0FFE;

  assign outs2 = {b2.h_ack_o, b2.h_rdata_o, b2.i_ack_o, b2.i_rdata_o, b2.reg_wen_o, b2.reg_ren_o,
                  b2.reg_addr_o, b2.reg_wbe_o, b2.reg_d_o, b2.busy_o, b2.gnt_o};
  assign outs0 = {b0.h_ack_o, b0.h_rdata_o, b0.i_ack_o, b0.i_rdata_o, b0.reg_wen_o, b0.reg_ren_o,
                  b0.reg_addr_o, b0.reg_wbe_o, b0.reg_d_o, b0.busy_o, b0.gnt_o};

  always @(negedge clk_i) begin
    if (b2.h_ack_o) hobs.push_back(ack_t'{cyc, b2.h_rdata_o});
    if (b2.i_ack_o) iobs.push_back(ack_t'{cyc, b2.i_rdata_o});
    if (b2.reg_wen_o || b2.reg_ren_o) begin
      gseq.push_back(b2.gnt_o);
      if (b2.gnt_o) isobs.push_back(stb_t'{cyc, skey(b2.reg_wen_o, b2.reg_addr_o, b2.reg_wbe_o, b2.reg_d_o)});
      else hsobs.push_back(stb_t'{cyc, skey(b2.reg_wen_o, b2.reg_addr_o, b2.reg_wbe_o, b2.reg_d_o)});
    end
  end

  // requester agents: hold req until ack, then either present the next queued request or drop req
  initial begin : h_agent
    req_t r;
    {b2.h_req_i, b2.h_we_i, b2.h_addr_i, b2.h_wbe_i, b2.h_wdata_i} = '0;
    forever begin
      @(negedge clk_i);
      if (!b2.h_req_i || b2.h_ack_o) begin
        if (hreq_q.size() > 0) begin
          r = hreq_q.pop_front();
          hst_q.push_back(cyc + (b2.h_req_i ? 1 : 0));
          {b2.h_we_i, b2.h_addr_i, b2.h_wbe_i, b2.h_wdata_i} = {r.we, r.a, r.be, r.d};
          b2.h_req_i = 1'b1;
        end else b2.h_req_i = 1'b0;
      end
    end
  end

  initial begin : i_agent
    req_t r;
    {b2.i_req_i, b2.i_we_i, b2.i_addr_i, b2.i_wbe_i, b2.i_wdata_i} = '0;
    forever begin
      @(negedge clk_i);
      if (!b2.i_req_i || b2.i_ack_o) begin
        if (ireq_q.size() > 0) begin
          r = ireq_q.pop_front();
          {b2.i_we_i, b2.i_addr_i, b2.i_wbe_i, b2.i_wdata_i} = {r.we, r.a, r.be, r.d};
          b2.i_req_i = 1'b1;
        end else b2.i_req_i = 1'b0;
      end
    end
  end

  task automatic send(input logic who, input logic we, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [AW-1:0] al = a & ~AW'(3);
    if (!who) begin
      hreq_q.push_back(req_t'{we, a, be, d});
      hsexp.push_back(skey(we, al, be, d));
      if (!we) exp_hrd = rv(al);
      hexp.push_back(exp_hrd);
    end else begin
      ireq_q.push_back(req_t'{we, a, be, d});
      isexp.push_back(skey(we, al, be, d));
      if (!we) exp_ird = rv(al);
      iexp.push_back(exp_ird);
    end
  endtask

  task automatic flush();
    hexp.delete(); iexp.delete(); hsexp.delete(); isexp.delete();
    hobs.delete(); iobs.delete(); hsobs.delete(); isobs.delete(); gseq.delete(); hst_q.delete();
  endtask

  task automatic wait_acks(input int nh, input int ni);
    for (int k = 0; k < 100 && (hobs.size() < nh || iobs.size() < ni); k++) begin @(negedge clk_i); #1; end
    repeat (3) begin @(negedge clk_i); #1; end
  endtask

  task automatic test_reset();
    srst_n_i = 1'b0;
    send(1'b0, 1'b1, 17'h00100, 4'hF, 32'h11111111);
    send(1'b1, 1'b1, 17'h00200, 4'hF, 32'h22222222);
    @(posedge clk_i);
    repeat (2) begin
      @(negedge clk_i); #1;
      n_cmp++; if (outs2 !== '0 || !b2.h_req_i || !b2.i_req_i) begin n_err++; $display("FAIL reset_outs2 got %h want 0", outs2); end
      n_cmp++; if (outs0 !== '0) begin n_err++; $display("FAIL reset_outs0 got %h want 0", outs0); end
    end
    n_cmp++; if (gseq.size() != 0) begin n_err++; $display("FAIL reset_strobes got %0d want 0", gseq.size()); end
    srst_n_i = 1'b1;
    wait_acks(1, 1);
    n_cmp++; if (gseq.size() != 2 || gseq[0] !== 1'b0 || gseq[1] !== 1'b1) begin n_err++; $display("FAIL reset_first_grant got n=%0d g0=%b want n=2 g0=0", gseq.size(), gseq.size() > 0 ? gseq[0] : 1'bx); end
    n_cmp++; if (hobs.size() != 1 || iobs.size() != 1) begin n_err++; $display("FAIL reset_acks got %0d/%0d want 1/1", hobs.size(), iobs.size()); end
    flush();
  endtask

  task automatic test_write();
    stb_t s; ack_t a; int st;
    send(1'b0, 1'b1, 17'h00008, 4'hF, 32'hDEADBEEF);
    wait_acks(1, 0);
    n_cmp++; if (hsobs.size() != 1 || hobs.size() != 1 || hst_q.size() != 1) begin n_err++; $display("FAIL wr_counts got stb=%0d ack=%0d want 1/1", hsobs.size(), hobs.size()); end
    if (hsobs.size() > 0 && hobs.size() > 0 && hst_q.size() > 0) begin
      s = hsobs.pop_front(); a = hobs.pop_front(); st = hst_q.pop_front();
      n_cmp++; if (s.cyc != st + 1) begin n_err++; $display("FAIL wr_stb_cycle got %0d want %0d", s.cyc, st + 1); end
      n_cmp++; if (s.k !== hsexp[0]) begin n_err++; $display("FAIL wr_stb_fields got %h want %h", s.k, hsexp[0]); end
      n_cmp++; if (a.cyc != st + 2) begin n_err++; $display("FAIL wr_ack_cycle got %0d want %0d", a.cyc, st + 2); end
      n_cmp++; if (a.rd !== hexp[0]) begin n_err++; $display("FAIL wr_rdata_held got %h want %h", a.rd, hexp[0]); end
    end
    flush();
  endtask

  task automatic test_read();
    stb_t s; ack_t a; int st, k0, c = -1;
    send(1'b0, 1'b0, 17'h0000C, 4'hF, 32'h0);
    wait_acks(1, 0);
    n_cmp++; if (hsobs.size() != 1 || hobs.size() != 1) begin n_err++; $display("FAIL rd_counts got stb=%0d ack=%0d want 1/1", hsobs.size(), hobs.size()); end
    if (hsobs.size() > 0 && hobs.size() > 0 && hst_q.size() > 0) begin
      s = hsobs.pop_front(); a = hobs.pop_front(); st = hst_q.pop_front();
      n_cmp++; if (s.cyc != st + 1 || s.k !== hsexp[0]) begin n_err++; $display("FAIL rd_stb got cyc=%0d k=%h want cyc=%0d k=%h", s.cyc, s.k, st + 1, hsexp[0]); end
      n_cmp++; if (a.cyc != st + 4) begin n_err++; $display("FAIL rd_ack_cycle got %0d want %0d", a.cyc, st + 4); end
      n_cmp++; if (a.rd !== hexp[0]) begin n_err++; $display("FAIL rd_rdata got %h want %h", a.rd, hexp[0]); end
    end
    n_cmp++; if (b2.i_rdata_o !== exp_ird) begin n_err++; $display("FAIL rd_other_rdata got %h want %h", b2.i_rdata_o, exp_ird); end
    flush();
    {b0.h_we_i, b0.h_addr_i, b0.h_wbe_i, b0.h_wdata_i} = {1'b0, 17'h0000C, 4'hF, 32'h0};
    b0.h_req_i = 1'b1;
    k0 = cyc;
    for (int k = 0; k < 10 && c < 0; k++) begin
      @(negedge clk_i); #1;
      if (b0.h_ack_o) begin c = cyc; b0.h_req_i = 1'b0; end
    end
    b0.h_req_i = 1'b0;
    n_cmp++; if (c != k0 + 2) begin n_err++; $display("FAIL rd0_ack_cycle got %0d want %0d", c, k0 + 2); end
    n_cmp++; if (b0.h_rdata_o !== 32'h12345678 || b0.i_rdata_o !== 32'h0) begin n_err++; $display("FAIL rd0_rdata got %h/%h want 12345678/0", b0.h_rdata_o, b0.i_rdata_o); end
    repeat (3) begin @(negedge clk_i); #1; end
  endtask

  task automatic test_contention();
    logic [3:0] gs = 'x;
    ack_t a; stb_t s;
    srst_n_i = 1'b0;
    exp_hrd = '0; exp_ird = '0;
    send(1'b0, 1'b1, 17'h00040, 4'hF, 32'hAAAA5555);
    send(1'b0, 1'b0, 17'h00044, 4'hF, 32'h0);
    send(1'b1, 1'b0, 17'h00080, 4'hF, 32'h0);
    send(1'b1, 1'b1, 17'h00084, 4'hC, 32'h0BADF00D);
    repeat (2) begin @(negedge clk_i); #1; end
    srst_n_i = 1'b1;
    wait_acks(2, 2);
    for (int k = 0; k < 4 && k < gseq.size(); k++) gs[k] = gseq[k];
    n_cmp++; if (gseq.size() != 4 || gs !== 4'b1010) begin n_err++; $display("FAIL cont_grants got n=%0d seq=%b want n=4 seq=1010", gseq.size(), gs); end
    n_cmp++; if (hobs.size() != 2 || iobs.size() != 2) begin n_err++; $display("FAIL cont_acks got %0d/%0d want 2/2", hobs.size(), iobs.size()); end
    while (hobs.size() > 0 && hexp.size() > 0) begin
      a = hobs.pop_front();
      n_cmp++; if (a.rd !== hexp[0]) begin n_err++; $display("FAIL cont_h_rdata got %h want %h", a.rd, hexp[0]); end
      void'(hexp.pop_front());
    end
    while (iobs.size() > 0 && iexp.size() > 0) begin
      a = iobs.pop_front();
      n_cmp++; if (a.rd !== iexp[0]) begin n_err++; $display("FAIL cont_i_rdata got %h want %h", a.rd, iexp[0]); end
      void'(iexp.pop_front());
    end
    while (isobs.size() > 0 && isexp.size() > 0) begin
      s = isobs.pop_front();
      n_cmp++; if (s.k !== isexp[0]) begin n_err++; $display("FAIL cont_i_stb got %h want %h", s.k, isexp[0]); end
      void'(isexp.pop_front());
    end
    flush();
  endtask

  task automatic test_int_write();
    stb_t s; ack_t a;
    send(1'b1, 1'b1, 17'h0000B, 4'h3, 32'h0000BEEF);
    send(1'b1, 1'b1, 17'h00010, 4'h0, 32'h00000055);
    wait_acks(0, 2);
    n_cmp++; if (isobs.size() != 2 || iobs.size() != 2) begin n_err++; $display("FAIL iwr_counts got stb=%0d ack=%0d want 2/2", isobs.size(), iobs.size()); end
    while (isobs.size() > 0 && isexp.size() > 0) begin
      s = isobs.pop_front();
      n_cmp++; if (s.k !== isexp[0]) begin n_err++; $display("FAIL iwr_stb got %h want %h", s.k, isexp[0]); end
      void'(isexp.pop_front());
    end
    while (iobs.size() > 0 && iexp.size() > 0) begin
      a = iobs.pop_front();
      n_cmp++; if (a.rd !== iexp[0]) begin n_err++; $display("FAIL iwr_rdata got %h want %h", a.rd, iexp[0]); end
      void'(iexp.pop_front());
    end
    n_cmp++; if (b2.reg_addr_o !== 17'h00010 || b2.reg_wbe_o !== 4'h0 || b2.reg_d_o !== 32'h55) begin n_err++; $display("FAIL iwr_hold got %h/%h/%h want 00010/0/00000055", b2.reg_addr_o, b2.reg_wbe_o, b2.reg_d_o); end
    flush();
  endtask

  task automatic test_reset_wait();
    ack_t a; int r;
    send(1'b0, 1'b0, 17'h00020, 4'hF, 32'h0);
    for (int k = 0; k < 20 && hsobs.size() == 0; k++) begin @(negedge clk_i); #1; end
    @(negedge clk_i); #1;
    srst_n_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i); #1;
      n_cmp++; if (outs2 !== '0) begin n_err++; $display("FAIL rstw_outs got %h want 0", outs2); end
    end
    n_cmp++; if (hobs.size() != 0) begin n_err++; $display("FAIL rstw_no_ack got %0d want 0", hobs.size()); end
    srst_n_i = 1'b1;
    r = cyc;
    wait_acks(1, 0);
    n_cmp++; if (hobs.size() != 1) begin n_err++; $display("FAIL rstw_reissue_acks got %0d want 1", hobs.size()); end
    if (hobs.size() > 0) begin
      a = hobs.pop_front();
      n_cmp++; if (a.cyc != r + 4 || a.rd !== rv(17'h00020)) begin n_err++; $display("FAIL rstw_reissue got cyc=%0d rd=%h want cyc=%0d rd=%h", a.cyc, a.rd, r + 4, rv(17'h00020)); end
    end
    flush();
  endtask

  initial begin
    {b0.h_req_i, b0.h_we_i, b0.h_addr_i, b0.h_wbe_i, b0.h_wdata_i} = '0;
    {b0.i_req_i, b0.i_we_i, b0.i_addr_i, b0.i_wbe_i, b0.i_wdata_i} = '0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_int_write();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
